// File: rtl/vga_paddle_ctrl.sv
// Paddle controller for a VGA scan: buttons steer a horizontal bar, position updates once per frame tick.
// Optional macro PADDLE_ACCEL_EN enables speed ramping from STEP_MIN to STEP_MAX while a direction is held.
module vga_paddle_ctrl #(
    parameter int BAR_WIDTH   = 64,
    parameter int BAR_TOP     = 470,
    parameter int BAR_BOTTOM  = 475,
    parameter int MAX_X       = 640,
    parameter int TICK_Y      = 481,
    parameter int STEP_MIN    = 2,
    parameter int STEP_MAX    = 8,
    parameter int RAMP_FRAMES = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       btn_l_n,
    input  logic       btn_r_n,
    input  logic       enable,
    output logic       bar_pix,
    output logic [9:0] bar_left,
    output logic [9:0] bar_right,
    output logic       moving
);

    typedef enum logic [1:0] {IDLE, RAMP, CRUISE} state_t;
    typedef enum logic [1:0] {DIR_NONE, DIR_LEFT, DIR_RIGHT} dir_t;

    localparam logic [10:0] LIMIT_R    = 11'(MAX_X - BAR_WIDTH);
    localparam logic [9:0]  CENTER     = 10'((MAX_X - BAR_WIDTH) / 2);
    localparam logic [9:0]  WIDTH_M1   = 10'(BAR_WIDTH - 1);
    localparam logic [9:0]  ROW_TOP    = 10'(BAR_TOP);
    localparam logic [9:0]  ROW_BOTTOM = 10'(BAR_BOTTOM);
    localparam logic [9:0]  ROW_TICK   = 10'(TICK_Y);
    localparam logic [10:0] STEP_MIN_W = 11'(STEP_MIN);
    localparam logic [10:0] STEP_MAX_W = 11'(STEP_MAX);
    localparam logic [7:0]  CNT_LAST   = 8'(RAMP_FRAMES - 1);

    // Clamped move in 11-bit arithmetic so underflow/overflow never wraps.
    function automatic logic [9:0] moveBar(input logic [9:0] pos, input logic [10:0] stepSize,
                                           input dir_t dir);
        logic [10:0] wide;
        wide = {1'b0, pos};
        moveBar = pos;
        if (dir == DIR_LEFT) begin
            if (wide < stepSize) moveBar = '0;
            else                 moveBar = 10'(wide - stepSize);
        end else if (dir == DIR_RIGHT) begin
            if (wide + stepSize > LIMIT_R) moveBar = LIMIT_R[9:0];
            else                           moveBar = 10'(wide + stepSize);
        end
    endfunction

    logic   btnLMeta_p0, btnLSync_p1, btnRMeta_p0, btnRSync_p1;
    logic   cond, condQ, tick;
    dir_t   dirNow, curDir, dirNext;
    state_t state, stateNext;
    logic [10:0] step, stepNext, moveStep;
    logic [7:0]  rampCnt, cntNext;
    logic [9:0]  leftNext;
    dir_t        moveDir;

    // Stage p0/p1: two-flop synchronizers, released (high) out of reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            btnLMeta_p0 <= 1'b1;
            btnLSync_p1 <= 1'b1;
            btnRMeta_p0 <= 1'b1;
            btnRSync_p1 <= 1'b1;
        end else begin
            btnLMeta_p0 <= btn_l_n;
            btnLSync_p1 <= btnLMeta_p0;
            btnRMeta_p0 <= btn_r_n;
            btnRSync_p1 <= btnRMeta_p0;
        end
    end

    assign cond = (pixel_y == ROW_TICK) && (pixel_x == 10'd0);
    assign tick = cond && !condQ;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) condQ <= 1'b0;
        else       condQ <= cond;
    end

    always_comb begin
        dirNow = DIR_NONE;
        if (!btnLSync_p1 && btnRSync_p1)      dirNow = DIR_LEFT;
        else if (btnLSync_p1 && !btnRSync_p1) dirNow = DIR_RIGHT;
    end

    always_comb begin
        stateNext = state;
        dirNext   = curDir;
        stepNext  = step;
        cntNext   = rampCnt;
        moveStep  = STEP_MIN_W;
        moveDir   = DIR_NONE;
        if (!enable) begin
            stateNext = IDLE;
        end else if (tick) begin
            case (state)
                IDLE: begin
                    if (dirNow != DIR_NONE) begin
                        stateNext = RAMP;
                        dirNext   = dirNow;
                        stepNext  = STEP_MIN_W;
                        cntNext   = '0;
                        moveDir   = dirNow;
                    end
                end
                RAMP, CRUISE: begin
                    if (dirNow == DIR_NONE) begin
                        stateNext = IDLE;
                    end else if (dirNow != curDir) begin
                        stateNext = RAMP;
                        dirNext   = dirNow;
                        stepNext  = STEP_MIN_W;
                        cntNext   = '0;
                        moveDir   = dirNow;
                    end else if (state == CRUISE) begin
                        moveDir  = curDir;
                        moveStep = STEP_MAX_W;
                    end else begin
                        moveDir  = curDir;
                        moveStep = step;
                        if (rampCnt + 8'd1 == CNT_LAST) begin
                            cntNext = '0;
`ifdef PADDLE_ACCEL_EN
                            stepNext = step + 11'd1;
                            if (step + 11'd1 == STEP_MAX_W) stateNext = CRUISE;
`endif
                        end else begin
                            cntNext = rampCnt + 8'd1;
                        end
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
        // A move clamped at a wall still commits the state/counter updates above.
        leftNext = moveBar(bar_left, moveStep, moveDir);
    end

    // Stage p1: state and position registers, new position visible one clock after the tick edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            curDir   <= DIR_NONE;
            step     <= STEP_MIN_W;
            rampCnt  <= '0;
            bar_left <= CENTER;
        end else begin
            state    <= stateNext;
            curDir   <= dirNext;
            step     <= stepNext;
            rampCnt  <= cntNext;
            bar_left <= leftNext;
        end
    end

    assign bar_right = bar_left + WIDTH_M1;
    assign moving    = (state != IDLE);
    assign bar_pix   = (pixel_x >= bar_left) && (pixel_x <= bar_right) &&
                       (pixel_y >= ROW_TOP) && (pixel_y <= ROW_BOTTOM);

endmodule

// File: tb/tb_vga_paddle_ctrl.sv
// Directed bench for vga_paddle_ctrl: default instance plus an odd-centred instance (BAR_WIDTH=58) for partial wall clamps.
module tb_vga_paddle_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic [9:0] pixel_x, pixel_y;
    logic       btn_l_n, btn_r_n, enable;
    logic       bar_pix, moving, oddPix, oddMoving;
    logic [9:0] bar_left, bar_right, oddLeft, oddRight;
    int         compared = 0;
    int         mismatched = 0;

    always #5 clock = ~clock;

    vga_paddle_ctrl dut (
        .clock(clock), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .btn_l_n(btn_l_n), .btn_r_n(btn_r_n), .enable(enable),
        .bar_pix(bar_pix), .bar_left(bar_left), .bar_right(bar_right), .moving(moving)
    );

    vga_paddle_ctrl #(.BAR_WIDTH(58)) dutOdd (
        .clock(clock), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .btn_l_n(btn_l_n), .btn_r_n(btn_r_n), .enable(enable),
        .bar_pix(oddPix), .bar_left(oddLeft), .bar_right(oddRight), .moving(oddMoving)
    );

    task automatic setButtons(input logic l, input logic r);
        @(negedge clock);
        btn_l_n = ~l;
        btn_r_n = ~r;
        repeat (3) @(negedge clock);
    endtask

    task automatic frame(input int hold);
        @(negedge clock);
        pixel_y = 10'd481;
        pixel_x = 10'd0;
        repeat (hold) @(negedge clock);
        pixel_y = 10'd100;
        pixel_x = 10'd100;
    endtask

    task automatic doReset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; btn_l_n = 1'b1; btn_r_n = 1'b1;
        pixel_x = 10'd300; pixel_y = 10'd470;
        #12;
        compared++; if (bar_left !== 10'd288) begin mismatched++; $display("FAIL reset_left got %0d want 288", bar_left); end
        compared++; if (bar_right !== 10'd351) begin mismatched++; $display("FAIL reset_right got %0d want 351", bar_right); end
        compared++; if (moving !== 1'b0) begin mismatched++; $display("FAIL reset_moving got %b want 0", moving); end
        compared++; if (bar_pix !== 1'b1) begin mismatched++; $display("FAIL reset_pix got %b want 1", bar_pix); end
        compared++; if (oddLeft !== 10'd291) begin mismatched++; $display("FAIL reset_odd_left got %0d want 291", oddLeft); end
        @(negedge clock);
        reset = 1'b0;
        pixel_x = 10'd100; pixel_y = 10'd100;
    endtask

    task automatic test_tick_once();
        frame(5);
        compared++; if (bar_left !== 10'd288) begin mismatched++; $display("FAIL idle_tick_left got %0d want 288", bar_left); end
        compared++; if (moving !== 1'b0) begin mismatched++; $display("FAIL idle_tick_moving got %b want 0", moving); end
        setButtons(1'b1, 1'b0);
        frame(5);
        compared++; if (bar_left !== 10'd286) begin mismatched++; $display("FAIL one_tick_left got %0d want 286", bar_left); end
        compared++; if (moving !== 1'b1) begin mismatched++; $display("FAIL one_tick_moving got %b want 1", moving); end
    endtask

    task automatic test_both_none();
        frame(1);
        compared++; if (bar_left !== 10'd284) begin mismatched++; $display("FAIL ramp_left got %0d want 284", bar_left); end
        setButtons(1'b1, 1'b1);
        frame(1);
        compared++; if (bar_left !== 10'd284) begin mismatched++; $display("FAIL both_left got %0d want 284", bar_left); end
        compared++; if (moving !== 1'b0) begin mismatched++; $display("FAIL both_moving got %b want 0", moving); end
        setButtons(1'b1, 1'b0);
        frame(1);
        compared++; if (bar_left !== 10'd282) begin mismatched++; $display("FAIL restart_left got %0d want 282", bar_left); end
        setButtons(1'b0, 1'b0);
        frame(1);
        compared++; if (bar_left !== 10'd282) begin mismatched++; $display("FAIL none_left got %0d want 282", bar_left); end
        compared++; if (moving !== 1'b0) begin mismatched++; $display("FAIL none_moving got %b want 0", moving); end
    endtask

    task automatic test_reverse();
        setButtons(1'b1, 1'b0);
        frame(1);
        compared++; if (bar_left !== 10'd280) begin mismatched++; $display("FAIL pre_rev_left got %0d want 280", bar_left); end
        setButtons(1'b0, 1'b1);
        frame(1);
        compared++; if (bar_left !== 10'd282) begin mismatched++; $display("FAIL rev_left got %0d want 282", bar_left); end
        compared++; if (moving !== 1'b1) begin mismatched++; $display("FAIL rev_moving got %b want 1", moving); end
        frame(1);
        compared++; if (bar_left !== 10'd284) begin mismatched++; $display("FAIL rev2_left got %0d want 284", bar_left); end
    endtask

    task automatic test_enable();
        @(negedge clock);
        enable = 1'b0;
        @(negedge clock);
        compared++; if (moving !== 1'b0) begin mismatched++; $display("FAIL dis_moving got %b want 0", moving); end
        repeat (3) frame(1);
        compared++; if (bar_left !== 10'd284) begin mismatched++; $display("FAIL dis_left got %0d want 284", bar_left); end
        compared++; if (moving !== 1'b0) begin mismatched++; $display("FAIL dis_moving3 got %b want 0", moving); end
        @(negedge clock);
        enable = 1'b1;
        frame(1);
        compared++; if (bar_left !== 10'd286) begin mismatched++; $display("FAIL reen_left got %0d want 286", bar_left); end
        compared++; if (moving !== 1'b1) begin mismatched++; $display("FAIL reen_moving got %b want 1", moving); end
    endtask

    task automatic test_reset_mid();
        setButtons(1'b1, 1'b0);
        frame(1);
        compared++; if (bar_left !== 10'd284) begin mismatched++; $display("FAIL mid_pre_left got %0d want 284", bar_left); end
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        compared++; if (bar_left !== 10'd288) begin mismatched++; $display("FAIL async_rst_left got %0d want 288", bar_left); end
        compared++; if (moving !== 1'b0) begin mismatched++; $display("FAIL async_rst_moving got %b want 0", moving); end
        @(negedge clock);
        reset = 1'b0;
        setButtons(1'b0, 1'b0);
        frame(1);
        compared++; if (bar_left !== 10'd288 || moving !== 1'b0) begin mismatched++; $display("FAIL post_rst_idle got %0d/%b want 288/0", bar_left, moving); end
        setButtons(1'b1, 1'b0);
        frame(1);
        compared++; if (bar_left !== 10'd286) begin mismatched++; $display("FAIL post_rst_move got %0d want 286", bar_left); end
    endtask

`ifdef PADDLE_ACCEL_EN
    task automatic test_accel_ramp();
        logic [9:0] expTab [10] = '{10'd286, 10'd284, 10'd282, 10'd280, 10'd278,
                                    10'd276, 10'd274, 10'd272, 10'd269, 10'd266};
        doReset();
        setButtons(1'b1, 1'b0);
        for (int k = 0; k < 10; k++) begin
            frame(1);
            compared++; if (bar_left !== expTab[k]) begin mismatched++; $display("FAIL accel_frame%0d got %0d want %0d", k + 1, bar_left, expTab[k]); end
        end
        repeat (33) frame(1);
        compared++; if (bar_left !== 10'd97) begin mismatched++; $display("FAIL accel_frame43 got %0d want 97", bar_left); end
        frame(1);
        compared++; if (bar_left !== 10'd89) begin mismatched++; $display("FAIL cruise1 got %0d want 89", bar_left); end
        frame(1);
        compared++; if (bar_left !== 10'd81) begin mismatched++; $display("FAIL cruise2 got %0d want 81", bar_left); end
    endtask

    task automatic test_cruise_reverse();
        setButtons(1'b0, 1'b1);
        frame(1);
        compared++; if (bar_left !== 10'd83) begin mismatched++; $display("FAIL cruise_rev got %0d want 83", bar_left); end
        frame(1);
        compared++; if (bar_left !== 10'd85) begin mismatched++; $display("FAIL cruise_rev2 got %0d want 85", bar_left); end
        setButtons(1'b1, 1'b1);
        frame(1);
        compared++; if (bar_left !== 10'd85 || moving !== 1'b0) begin mismatched++; $display("FAIL cruise_both got %0d/%b want 85/0", bar_left, moving); end
    endtask
`else
    task automatic test_fixed_step();
        doReset();
        setButtons(1'b1, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            frame(1);
            compared++; if (bar_left !== 10'(288 - 2 * k)) begin mismatched++; $display("FAIL fixed_frame%0d got %0d want %0d", k, bar_left, 288 - 2 * k); end
        end
        compared++; if (moving !== 1'b1) begin mismatched++; $display("FAIL fixed_moving got %b want 1", moving); end
    endtask

    task automatic test_left_wall();
        int expMain, expOdd;
        for (int k = 21; k <= 147; k++) begin
            frame(1);
            expMain = (288 > 2 * k) ? 288 - 2 * k : 0;
            expOdd  = (291 > 2 * k) ? 291 - 2 * k : 0;
            compared++; if (bar_left !== 10'(expMain)) begin mismatched++; $display("FAIL lwall_main%0d got %0d want %0d", k, bar_left, expMain); end
            compared++; if (oddLeft !== 10'(expOdd)) begin mismatched++; $display("FAIL lwall_odd%0d got %0d want %0d", k, oddLeft, expOdd); end
        end
        compared++; if (moving !== 1'b1 || oddMoving !== 1'b1) begin mismatched++; $display("FAIL lwall_moving got %b/%b want 1/1", moving, oddMoving); end
        @(negedge clock); pixel_x = 10'd0; pixel_y = 10'd470; #1;
        compared++; if (bar_pix !== 1'b1 || oddPix !== 1'b1) begin mismatched++; $display("FAIL lwall_pix0 got %b/%b want 1/1", bar_pix, oddPix); end
        pixel_x = 10'd63; pixel_y = 10'd475; #1;
        compared++; if (bar_pix !== 1'b1) begin mismatched++; $display("FAIL lwall_pix63 got %b want 1", bar_pix); end
        pixel_x = 10'd64; pixel_y = 10'd470; #1;
        compared++; if (bar_pix !== 1'b0) begin mismatched++; $display("FAIL lwall_pix64 got %b want 0", bar_pix); end
        pixel_x = 10'd10; pixel_y = 10'd476; #1;
        compared++; if (bar_pix !== 1'b0) begin mismatched++; $display("FAIL lwall_pixrow476 got %b want 0", bar_pix); end
        pixel_y = 10'd469; #1;
        compared++; if (bar_pix !== 1'b0) begin mismatched++; $display("FAIL lwall_pixrow469 got %b want 0", bar_pix); end
        pixel_x = 10'd100; pixel_y = 10'd100;
    endtask

    task automatic test_right_wall();
        int expMain, expOdd;
        doReset();
        setButtons(1'b0, 1'b1);
        for (int k = 1; k <= 147; k++) begin
            frame(1);
            expMain = (288 + 2 * k < 576) ? 288 + 2 * k : 576;
            expOdd  = (291 + 2 * k < 582) ? 291 + 2 * k : 582;
            compared++; if (bar_left !== 10'(expMain)) begin mismatched++; $display("FAIL rwall_main%0d got %0d want %0d", k, bar_left, expMain); end
            compared++; if (oddLeft !== 10'(expOdd)) begin mismatched++; $display("FAIL rwall_odd%0d got %0d want %0d", k, oddLeft, expOdd); end
        end
        compared++; if (bar_right !== 10'd639 || oddRight !== 10'd639) begin mismatched++; $display("FAIL rwall_right got %0d/%0d want 639/639", bar_right, oddRight); end
        compared++; if (moving !== 1'b1) begin mismatched++; $display("FAIL rwall_moving got %b want 1", moving); end
        @(negedge clock); pixel_x = 10'd575; pixel_y = 10'd470; #1;
        compared++; if (bar_pix !== 1'b0) begin mismatched++; $display("FAIL rwall_pix575 got %b want 0", bar_pix); end
        pixel_x = 10'd576; #1;
        compared++; if (bar_pix !== 1'b1) begin mismatched++; $display("FAIL rwall_pix576 got %b want 1", bar_pix); end
        pixel_x = 10'd639; pixel_y = 10'd475; #1;
        compared++; if (bar_pix !== 1'b1) begin mismatched++; $display("FAIL rwall_pix639 got %b want 1", bar_pix); end
        pixel_y = 10'd476; #1;
        compared++; if (bar_pix !== 1'b0) begin mismatched++; $display("FAIL rwall_pixrow476 got %b want 0", bar_pix); end
        pixel_x = 10'd600; pixel_y = 10'd469; #1;
        compared++; if (bar_pix !== 1'b0) begin mismatched++; $display("FAIL rwall_pixrow469 got %b want 0", bar_pix); end
        pixel_x = 10'd100; pixel_y = 10'd100;
    endtask
`endif

    initial begin
        test_reset();
        test_tick_once();
        test_both_none();
        test_reverse();
        test_enable();
        test_reset_mid();
`ifdef PADDLE_ACCEL_EN
        test_accel_ramp();
        test_cruise_reverse();
`else
        test_fixed_step();
        test_left_wall();
        test_right_wall();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/vga_paddle_ctrl.md
VGA_PADDLE_CTRL -- requirements
Module: vga_paddle_ctrl

Interface
REQ-001 Parameter BAR_WIDTH, default 64: paddle width in pixels.
REQ-002 Parameter BAR_TOP, default 470: first paddle row.
REQ-003 Parameter BAR_BOTTOM, default 475: last paddle row.
REQ-004 Parameter MAX_X, default 640: visible screen width.
REQ-005 Parameter TICK_Y, default 481: scan row that marks the frame tick.
REQ-006 Parameter STEP_MIN, default 2: start speed in pixels/frame.
REQ-007 Parameter STEP_MAX, default 8: top speed in pixels/frame.
REQ-008 Parameter RAMP_FRAMES, default 8: frames per +1 speed increment.
REQ-009 clock  in  1  system clock.
REQ-010 reset  in  1  asynchronous, active-high.
REQ-011 pixel_x  in  10  current scan column.
REQ-012 pixel_y  in  10  current scan row.
REQ-013 btn_l_n  in  1  left button, active-low, asynchronous to clock.
REQ-014 btn_r_n  in  1  right button, active-low, asynchronous to clock.
REQ-015 enable  in  1  high permits movement.
REQ-016 bar_pix  out  1  scan position lies inside the paddle.
REQ-017 bar_left  out  10  registered paddle left edge.
REQ-018 bar_right  out  10  bar_left+BAR_WIDTH-1, combinational.
REQ-019 moving  out  1  high when the state is not IDLE.

Function
REQ-020 Each button SHALL pass through a two-flop synchronizer before use.
REQ-021 tick SHALL equal cond AND NOT cond_q, where cond=(pixel_y==TICK_Y && pixel_x==0) and cond_q is cond registered; this gives exactly one tick per frame however long cond is held.
REQ-022 Direction SHALL be sampled on tick only: left-only pressed = LEFT; right-only pressed = RIGHT; both or neither = NONE.
REQ-023 FSM states SHALL be IDLE, RAMP and CRUISE, updated only on tick.
REQ-024 IDLE: on LEFT or RIGHT, go to RAMP with step=STEP_MIN and frame counter=0, and move by STEP_MIN on the same tick.
REQ-025 RAMP: on a tick with the same direction, move by step and increment the frame counter; when the counter reaches RAMP_FRAMES-1, step+=1 and the counter clears; when step reaches STEP_MAX, go to CRUISE.
REQ-026 CRUISE: on a tick with the same direction, move by STEP_MAX.
REQ-027 In RAMP or CRUISE, NONE SHALL go to IDLE with no move; a reversed direction SHALL go to RAMP with step=STEP_MIN and move STEP_MIN in the new direction.
REQ-028 Moves SHALL use 11-bit arithmetic and clamp exactly: LEFT gives max(0, bar_left-step); RIGHT gives min(MAX_X-BAR_WIDTH, bar_left+step).
REQ-029 A move that is clamped to zero displacement at a wall SHALL still keep the FSM state and counters as if the move had been made.
REQ-030 The new bar_left SHALL be visible on the clock after the tick edge (latency 1).
REQ-031 bar_pix SHALL be combinational: pixel_x in [bar_left, bar_right] AND pixel_y in [BAR_TOP, BAR_BOTTOM].
REQ-032 While enable=0, position SHALL freeze and the FSM SHALL be forced to IDLE on every clock; tick detection and the synchronizers keep running.

Reset
REQ-033 Reset SHALL set bar_left=(MAX_X-BAR_WIDTH)/2 (288 by default), state=IDLE, step=STEP_MIN, counter=0, cond_q=0 and the synchronizers to 1 (released).
REQ-034 Reset asserted during movement SHALL take effect immediately; the first tick after release starts from IDLE.

Configuration
REQ-035 With PADDLE_ACCEL_EN defined, the RAMP/CRUISE acceleration of REQ-025..026 SHALL apply.
REQ-036 Without PADDLE_ACCEL_EN, step SHALL be fixed at STEP_MIN, RAMP SHALL never advance step, and CRUISE SHALL be unreachable; all other behaviour is unchanged.

Verification
REQ-037 Reset, then hold cond for 5 clocks -> exactly one tick; bar_left=288, moving=0.
REQ-038 ACCEL_EN: hold btn_l_n=0 for 10 frames -> bar_left 286,284,282,280,278,276,274,272,269,266 (step 3 from frame 9).
REQ-039 bar_left=3, LEFT with step 2 -> 1, then 0, then stays 0 with moving=1.
REQ-040 RIGHT held from 570 -> clamps at 576; bar_pix=1 only at pixel_x 576..639, pixel_y 470..475.
REQ-041 Both buttons pressed on a tick -> IDLE, no move; reversing from CRUISE -> step 2 in the new direction.
REQ-042 enable=0 with buttons held for 3 frames -> bar_left unchanged, moving=0; without PADDLE_ACCEL_EN, 20 frames of LEFT -> 40 px total.
